bf16_operand_unpack: RTL and testbench

- Front-end decoder for the approximate BF16 multiplier; the counterpart of the back-end exception/pack stage.
- Accepts two packed BF16 operands through a valid/ready handshake.
- Unpacks each operand into sign, exponent and mantissa-with-hidden-bit, classifies it (zero/subnormal, Inf, NaN) and precomputes the biased exponent sum in the same 10-bit signed format the pack stage consumes.
- Also produces a ready-made special-case product so the datapath can bypass the mantissa multiplier.
- Two-stage registered pipeline with full backpressure.

---
 rtl/bf16_operand_unpack.sv | 187 ++++++++++++++++++
 tb/tb_bf16_operand_unpack.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/bf16_operand_unpack.sv
// BF16 multiplier front end: unpacks and classifies an operand pair, precomputes the
// biased exponent sum and a bypass product for special cases. Two-stage valid/ready pipe.

module bf16_operand_lane (
  input  logic       clk,
  input  logic       rst,
  input  logic       ld,
  input  logic [15:0] op,
  output logic       sign,
  output logic [7:0] exp,
  output logic [6:0] man,
  output logic       zero,
  output logic       inf,
  output logic       nan
);
  logic       sign_d, sign_q;
  logic [7:0] exp_d, exp_q;
  logic [6:0] man_d, man_q;
  logic       zero_d, zero_q;
  logic       inf_d, inf_q;
  logic       nan_d, nan_q;
  logic       is_max_exp;

  assign is_max_exp = (op[14:7] == 8'hFF);

  always_comb begin
    sign_d = sign_q;
    exp_d  = exp_q;
    man_d  = man_q;
    zero_d = zero_q;
    inf_d  = inf_q;
    nan_d  = nan_q;
    if (ld) begin
      sign_d = op[15];
      zero_d = (op[14:7] == 8'h00);
      // Subnormals flush to zero, so a zero operand contributes nothing to the exponent sum.
      exp_d  = zero_d ? 8'h00 : op[14:7];
      man_d  = op[6:0];
      inf_d  = is_max_exp & (op[6:0] == 7'h00);
      nan_d  = is_max_exp & (op[6:0] != 7'h00);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sign_q <= 1'b0;
      exp_q  <= 8'h00;
      man_q  <= 7'h00;
      zero_q <= 1'b0;
      inf_q  <= 1'b0;
      nan_q  <= 1'b0;
    end else begin
      sign_q <= sign_d;
      exp_q  <= exp_d;
      man_q  <= man_d;
      zero_q <= zero_d;
      inf_q  <= inf_d;
      nan_q  <= nan_d;
    end
  end

  assign sign = sign_q;
  assign exp  = exp_q;
  assign man  = man_q;
  assign zero = zero_q;
  assign inf  = inf_q;
  assign nan  = nan_q;
endmodule

module bf16_operand_unpack #(
  parameter int BIAS  = 127,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [15:0]      op_a,
  input  logic [15:0]      op_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             Spd,
  output logic [9:0]       expt_sum,
  output logic [7:0]       mant_a,
  output logic [7:0]       mant_b,
  output logic             is_special,
  output logic [15:0]      special_product,
  output logic [CNT_W-1:0] nan_count
);
  localparam int NUM_LANES = 2;
  localparam logic [15:0] QNAN = 16'h7FC0;

  typedef struct packed {
    logic        spd;
    logic [9:0]  expt_sum;
    logic [7:0]  mant_a;
    logic [7:0]  mant_b;
    logic        is_special;
    logic [15:0] special_product;
  } s2_t;

  logic [NUM_LANES-1:0][15:0] ops;
  logic [NUM_LANES-1:0]       s1_sign, s1_zero, s1_inf, s1_nan;
  logic [NUM_LANES-1:0][7:0]  s1_exp;
  logic [NUM_LANES-1:0][6:0]  s1_man;

  logic s1_valid_d, s1_valid_q;
  logic s2_valid_d, s2_valid_q;
  logic s1_adv, s2_adv, s1_ld, s2_ld, out_fire;
  s2_t  s2_d, s2_q, s2_calc;
  logic [CNT_W-1:0] nan_count_d, nan_count_q;

  assign s2_adv   = !s2_valid_q | out_ready;
  assign s1_adv   = !s1_valid_q | s2_adv;
  assign in_ready = s1_adv;
  assign s1_ld    = s1_adv & in_valid;
  assign s2_ld    = s2_adv & s1_valid_q;
  assign out_fire = s2_valid_q & out_ready;

  assign ops = {op_b, op_a};

  for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
    bf16_operand_lane u_lane (
      .clk  (clk),
      .rst  (rst),
      .ld   (s1_ld),
      .op   (ops[i]),
      .sign (s1_sign[i]),
      .exp  (s1_exp[i]),
      .man  (s1_man[i]),
      .zero (s1_zero[i]),
      .inf  (s1_inf[i]),
      .nan  (s1_nan[i])
    );
  end

  always_comb begin
    s2_calc          = '0;
    s2_calc.spd      = ^s1_sign;
    s2_calc.expt_sum = {2'b00, s1_exp[0]} + {2'b00, s1_exp[1]} - 10'(BIAS);
    s2_calc.mant_a   = s1_zero[0] ? 8'h00 : {1'b1, s1_man[0]};
    s2_calc.mant_b   = s1_zero[1] ? 8'h00 : {1'b1, s1_man[1]};
    // Inf x 0 is invalid and yields the same quiet NaN as a NaN input.
    if ((|s1_nan) || ((|s1_inf) && (|s1_zero))) begin
      s2_calc.is_special      = 1'b1;
      s2_calc.special_product = QNAN;
    end else if (|s1_inf) begin
      s2_calc.is_special      = 1'b1;
      s2_calc.special_product = {s2_calc.spd, 8'hFF, 7'h00};
    end else if (|s1_zero) begin
      s2_calc.is_special      = 1'b1;
      s2_calc.special_product = {s2_calc.spd, 15'h0000};
    end
  end

  always_comb begin
    s1_valid_d  = s1_adv ? in_valid : s1_valid_q;
    s2_valid_d  = s2_adv ? s1_valid_q : s2_valid_q;
    s2_d        = s2_ld ? s2_calc : s2_q;
    nan_count_d = nan_count_q;
    if (out_fire && (s2_q.special_product == QNAN) && (nan_count_q != {CNT_W{1'b1}}))
      nan_count_d = nan_count_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_q  <= 1'b0;
      s2_valid_q  <= 1'b0;
      s2_q        <= '0;
      nan_count_q <= '0;
    end else begin
      s1_valid_q  <= s1_valid_d;
      s2_valid_q  <= s2_valid_d;
      s2_q        <= s2_d;
      nan_count_q <= nan_count_d;
    end
  end

  assign out_valid       = s2_valid_q;
  assign Spd             = s2_q.spd;
  assign expt_sum        = s2_q.expt_sum;
  assign mant_a          = s2_q.mant_a;
  assign mant_b          = s2_q.mant_b;
  assign is_special      = s2_q.is_special;
  assign special_product = s2_q.special_product;
  assign nan_count       = nan_count_q;
endmodule

// File: tb/tb_bf16_operand_unpack.sv
// Directed bench for bf16_operand_unpack: hand-computed vectors, backpressure,
// mid-flight reset and nan_count saturation (counter narrowed to 4 bits).

module tb_bf16_operand_unpack;
  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] op_a, op_b;
  logic        out_valid;
  logic        out_ready;
  logic        Spd;
  logic [9:0]  expt_sum;
  logic [7:0]  mant_a, mant_b;
  logic        is_special;
  logic [15:0] special_product;
  logic [3:0]  nan_count;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  bf16_operand_unpack #(.BIAS(127), .CNT_W(4)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .op_a(op_a), .op_b(op_b), .out_valid(out_valid), .out_ready(out_ready),
    .Spd(Spd), .expt_sum(expt_sum), .mant_a(mant_a), .mant_b(mant_b),
    .is_special(is_special), .special_product(special_product), .nan_count(nan_count)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [15:0] a, input logic [15:0] b);
    in_valid = 1'b1;
    op_a = a;
    op_b = b;
    #1;
    chk("send_in_ready", 32'(in_ready), 32'd1);
    tick();
    in_valid = 1'b0;
  endtask

  logic [15:0] pa [4];
  logic [15:0] pb [4];
  logic [9:0]  pe [4];
  int idx, acc, got;
  logic fire;

  initial begin
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; op_a = '0; op_b = '0;
    tick(); tick();
    rst = 1'b0;
    #1;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_nan_count", 32'(nan_count), 32'd0);
    chk("rst_special", 32'(special_product), 32'd0);
    chk("rst_expt", 32'(expt_sum), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);

    // 1.0 x 2.0
    send(16'h3F80, 16'h4000);
    chk("norm_lat1", 32'(out_valid), 32'd0);
    tick();
    chk("norm_valid", 32'(out_valid), 32'd1);
    chk("norm_spd", 32'(Spd), 32'd0);
    chk("norm_expt", 32'(expt_sum), 32'd128);
    chk("norm_mant_a", 32'(mant_a), 32'h80);
    chk("norm_mant_b", 32'(mant_b), 32'h80);
    chk("norm_is_sp", 32'(is_special), 32'd0);
    chk("norm_sp", 32'(special_product), 32'h0000);
    tick();
    chk("norm_drain", 32'(out_valid), 32'd0);

    // -Inf x 0 -> qNaN
    send(16'hFF80, 16'h0000);
    tick();
    chk("infz_is_sp", 32'(is_special), 32'd1);
    chk("infz_sp", 32'(special_product), 32'h7FC0);
    chk("infz_cnt0", 32'(nan_count), 32'd0);
    tick();
    chk("infz_cnt1", 32'(nan_count), 32'd1);

    // subnormal A flushed: -0 x 1.0
    send(16'h8001, 16'h3F80);
    tick();
    chk("sub_is_sp", 32'(is_special), 32'd1);
    chk("sub_sp", 32'(special_product), 32'h8000);
    chk("sub_mant_a", 32'(mant_a), 32'h00);
    chk("sub_mant_b", 32'(mant_b), 32'h80);
    chk("sub_expt", 32'(expt_sum), 32'h000);
    tick();

    // smallest normals: 1+1-127 = -125
    send(16'h0080, 16'h0080);
    tick();
    chk("minexp_expt", 32'(expt_sum), 32'h383);
    chk("minexp_is_sp", 32'(is_special), 32'd0);
    tick();

    // +Inf x -1.0 -> -Inf
    send(16'h7F80, 16'hBF80);
    tick();
    chk("inf_sp", 32'(special_product), 32'hFF80);
    chk("inf_is_sp", 32'(is_special), 32'd1);
    tick();

    // NaN beats zero
    send(16'h7FC1, 16'h0000);
    tick();
    chk("nan_sp", 32'(special_product), 32'h7FC0);
    tick();
    chk("nan_cnt2", 32'(nan_count), 32'd2);

    // backpressure
    pa[0] = 16'h3F80; pb[0] = 16'h3F80; pe[0] = 10'd127;
    pa[1] = 16'h4000; pb[1] = 16'h3F80; pe[1] = 10'd128;
    pa[2] = 16'h4000; pb[2] = 16'h4000; pe[2] = 10'd129;
    pa[3] = 16'hC080; pb[3] = 16'h4000; pe[3] = 10'd130;
    out_ready = 1'b0;
    idx = 0; acc = 0;
    for (int c = 0; c < 4; c++) begin
      in_valid = 1'b1; op_a = pa[idx]; op_b = pb[idx];
      #1;
      fire = in_ready;
      if (c >= 2) chk("bp_stall_expt", 32'(expt_sum), 32'(pe[0]));
      tick();
      if (fire) begin acc++; idx++; end
    end
    chk("bp_accepted", 32'(acc), 32'd2);
    chk("bp_in_ready", 32'(in_ready), 32'd0);
    chk("bp_out_valid", 32'(out_valid), 32'd1);
    chk("bp_hold_expt", 32'(expt_sum), 32'(pe[0]));
    out_ready = 1'b1;
    got = 0;
    for (int c = 0; c < 12 && got < 4; c++) begin
      in_valid = (idx < 4);
      if (idx < 4) begin op_a = pa[idx]; op_b = pb[idx]; end
      #1;
      fire = in_valid & in_ready;
      if (out_valid) begin
        chk("bp_order_expt", 32'(expt_sum), 32'(pe[got]));
        got++;
      end
      tick();
      if (fire) idx++;
    end
    in_valid = 1'b0;
    chk("bp_got", 32'(got), 32'd4);
    chk("bp_spd_last", 32'(Spd), 32'd1);
    tick();
    chk("bp_no_dup", 32'(out_valid), 32'd0);

    // reset with two NaN pairs in flight
    in_valid = 1'b1; op_a = 16'h7FC1; op_b = 16'h3F80;
    tick();
    tick();
    in_valid = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    chk("mrst_out_valid", 32'(out_valid), 32'd0);
    chk("mrst_nan_count", 32'(nan_count), 32'd0);
    chk("mrst_sp", 32'(special_product), 32'd0);
    chk("mrst_is_sp", 32'(is_special), 32'd0);
    chk("mrst_in_ready", 32'(in_ready), 32'd1);
    for (int c = 0; c < 3; c++) begin
      tick();
      chk("mrst_no_stale", 32'(out_valid), 32'd0);
    end
    chk("mrst_cnt_hold", 32'(nan_count), 32'd0);

    // 20 NaN results into a 4-bit counter
    in_valid = 1'b1; op_a = 16'h7FC1; op_b = 16'h3F80;
    for (int c = 0; c < 20; c++) tick();
    in_valid = 1'b0;
    tick(); tick(); tick();
    chk("sat_nan_count", 32'(nan_count), 32'hF);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end
endmodule
